// File: rtl/synchronization.sv
// Receive-side PCS code-group synchronization (1000BASE-X style).
// Acquires comma alignment and tracks sync status, even/odd parity and SUDI.
module synchronization (
  input  logic       clock,
  input  logic       mr_main_reset,
  input  logic       mr_loopback,
  input  logic       signal_detect,
  input  logic [9:0] rx_code_group,
  output logic [9:0] SUDI,
  output logic       code_sync_status,
  output logic       rx_even
);

  typedef enum logic [12:0] {
    LOSS_OF_SYNC     = 13'b0000000000001,
    COMMA_DETECT_1   = 13'b0000000000010,
    ACQUIRE_SYNC_1   = 13'b0000000000100,
    COMMA_DETECT_2   = 13'b0000000001000,
    ACQUIRE_SYNC_2   = 13'b0000000010000,
    COMMA_DETECT_3   = 13'b0000000100000,
    SYNC_ACQUIRED_1  = 13'b0000001000000,
    SYNC_ACQUIRED_2  = 13'b0000010000000,
    SYNC_ACQUIRED_2A = 13'b0000100000000,
    SYNC_ACQUIRED_3  = 13'b0001000000000,
    SYNC_ACQUIRED_3A = 13'b0010000000000,
    SYNC_ACQUIRED_4  = 13'b0100000000000,
    SYNC_ACQUIRED_4A = 13'b1000000000000
  } state_t;

  state_t     state_q, state_d;
  logic       rx_even_q, rx_even_d;
  logic       status_q, status_d;
  logic [1:0] good_cgs_q, good_cgs_d;
  logic [9:0] sudi_q;

  logic [5:0] abcdei;
  logic [3:0] fghj;
  logic       valid6, valid4, is_comma, is_valid, is_k, is_d;
  logic       cgbad, cggood, link_ok;

  assign abcdei = rx_code_group[9:4];
  assign fghj   = rx_code_group[3:0];

  // 5b/6b sub-block, both running-disparity columns plus the K28 codes.
  always_comb begin
    valid6 = 1'b0;
    case (abcdei)
      6'b100111, 6'b011000,
      6'b011101, 6'b100010,
      6'b101101, 6'b010010,
      6'b110001,
      6'b110101, 6'b001010,
      6'b101001,
      6'b011001,
      6'b111000, 6'b000111,
      6'b111001, 6'b000110,
      6'b100101,
      6'b010101,
      6'b110100,
      6'b001101,
      6'b101100,
      6'b011100,
      6'b010111, 6'b101000,
      6'b011011, 6'b100100,
      6'b100011,
      6'b010011,
      6'b110010,
      6'b001011,
      6'b101010,
      6'b011010,
      6'b111010, 6'b000101,
      6'b110011, 6'b001100,
      6'b100110,
      6'b010110,
      6'b110110, 6'b001001,
      6'b001110,
      6'b101110, 6'b010001,
      6'b011110, 6'b100001,
      6'b101011, 6'b010100,
      6'b001111, 6'b110000: valid6 = 1'b1;
      default:              valid6 = 1'b0;
    endcase
  end

  // 3b/4b sub-block, including the alternate x.A7 encodings.
  always_comb begin
    valid4 = 1'b0;
    case (fghj)
      4'b1011, 4'b0100,
      4'b1001,
      4'b0101,
      4'b1100, 4'b0011,
      4'b1101, 4'b0010,
      4'b1010,
      4'b0110,
      4'b1110, 4'b0001,
      4'b0111, 4'b1000: valid4 = 1'b1;
      default:          valid4 = 1'b0;
    endcase
  end

  always_comb begin
    is_k = (abcdei == 6'b001111) || (abcdei == 6'b110000);
    case (rx_code_group)
      10'b111010_1000, 10'b000101_0111,
      10'b110110_1000, 10'b001001_0111,
      10'b101110_1000, 10'b010001_0111,
      10'b011110_1000, 10'b100001_0111: is_k = 1'b1;
      default: ;
    endcase
  end

  assign is_comma = (rx_code_group[9:3] == 7'b0011111) ||
                    (rx_code_group[9:3] == 7'b1100000);
  assign is_valid = valid6 & valid4;
  assign is_d     = is_valid & ~is_k;
  // A comma landing in an odd position counts as an error.
  assign cgbad    = ~is_valid | (is_comma & rx_even_q);
  assign cggood   = ~cgbad;
  assign link_ok  = signal_detect | mr_loopback;

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOSS_OF_SYNC:     if (link_ok && is_comma) state_d = COMMA_DETECT_1;
      COMMA_DETECT_1:   state_d = is_d ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
      ACQUIRE_SYNC_1: begin
        if (cgbad)                       state_d = LOSS_OF_SYNC;
        else if (!rx_even_q && is_comma) state_d = COMMA_DETECT_2;
      end
      COMMA_DETECT_2:   state_d = is_d ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
      ACQUIRE_SYNC_2: begin
        if (cgbad)                       state_d = LOSS_OF_SYNC;
        else if (!rx_even_q && is_comma) state_d = COMMA_DETECT_3;
      end
      COMMA_DETECT_3:   state_d = is_d ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
      SYNC_ACQUIRED_1:  if (cgbad) state_d = SYNC_ACQUIRED_2;
      SYNC_ACQUIRED_2:  state_d = cggood ? SYNC_ACQUIRED_2A : SYNC_ACQUIRED_3;
      SYNC_ACQUIRED_2A: begin
        if (cgbad)                   state_d = SYNC_ACQUIRED_3;
        else if (good_cgs_q == 2'd3) state_d = SYNC_ACQUIRED_1;
      end
      SYNC_ACQUIRED_3:  state_d = cggood ? SYNC_ACQUIRED_3A : SYNC_ACQUIRED_4;
      SYNC_ACQUIRED_3A: begin
        if (cgbad)                   state_d = SYNC_ACQUIRED_4;
        else if (good_cgs_q == 2'd3) state_d = SYNC_ACQUIRED_2;
      end
      SYNC_ACQUIRED_4:  state_d = cggood ? SYNC_ACQUIRED_4A : LOSS_OF_SYNC;
      SYNC_ACQUIRED_4A: begin
        if (cgbad)                   state_d = LOSS_OF_SYNC;
        else if (good_cgs_q == 2'd3) state_d = SYNC_ACQUIRED_3;
      end
      default:          state_d = LOSS_OF_SYNC;
    endcase
    if (!link_ok) state_d = LOSS_OF_SYNC;
  end

  // State actions are applied on every entry, self-loops included.
  always_comb begin
    rx_even_d  = ~rx_even_q;
    good_cgs_d = good_cgs_q;
    status_d   = 1'b0;
    case (state_d)
      COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3: rx_even_d = 1'b1;
      default: ;
    endcase
    case (state_d)
      SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4: good_cgs_d = 2'd0;
      SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A:
        good_cgs_d = good_cgs_q + 2'd1;
      default: ;
    endcase
    case (state_d)
      SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
      SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A,
      SYNC_ACQUIRED_4, SYNC_ACQUIRED_4A: status_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (mr_main_reset) begin
      state_q    <= LOSS_OF_SYNC;
      rx_even_q  <= 1'b0;
      status_q   <= 1'b0;
      good_cgs_q <= 2'd0;
      sudi_q     <= 10'd0;
    end else begin
      state_q    <= state_d;
      rx_even_q  <= rx_even_d;
      status_q   <= status_d;
      good_cgs_q <= good_cgs_d;
      sudi_q     <= rx_code_group;
    end
  end

  assign SUDI             = sudi_q;
  assign code_sync_status = status_q;
  assign rx_even          = rx_even_q;

endmodule

// File: tb/tb_synchronization.sv
// Directed and randomized checks of synchronization against a behavioural
// model built from the code tables and the acquire/loss rules.
module tb_synchronization;

  logic       clock = 1'b0;
  logic       mr_main_reset = 1'b1;
  logic       mr_loopback = 1'b0;
  logic       signal_detect = 1'b0;
  logic [9:0] rx_code_group = 10'd0;
  logic [9:0] SUDI;
  logic       code_sync_status;
  logic       rx_even;

  int errors = 0;
  int checks = 0;

  synchronization dut (
    .clock            (clock),
    .mr_main_reset    (mr_main_reset),
    .mr_loopback      (mr_loopback),
    .signal_detect    (signal_detect),
    .rx_code_group    (rx_code_group),
    .SUDI             (SUDI),
    .code_sync_status (code_sync_status),
    .rx_even          (rx_even)
  );

  always #5 clock = ~clock;

  localparam logic [9:0] K285  = 10'b0011111010;
  localparam logic [9:0] K285P = 10'b1100000101;
  localparam logic [9:0] D162  = 10'b1001000101;
  localparam logic [9:0] BAD   = 10'b0000000000;

  localparam logic [5:0] D6N [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [5:0] D6P [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  localparam logic [3:0] F4 [14] = '{
    4'b1011, 4'b0100, 4'b1001, 4'b0101, 4'b1100, 4'b0011, 4'b1101,
    4'b0010, 4'b1010, 4'b0110, 4'b1110, 4'b0001, 4'b0111, 4'b1000};
  localparam logic [9:0] K7 [8] = '{
    10'b1110101000, 10'b0001010111, 10'b1101101000, 10'b0010010111,
    10'b1011101000, 10'b0100010111, 10'b0111101000, 10'b1000010111};

  function automatic bit tb_valid(input logic [9:0] cg);
    bit v6 = (cg[9:4] == 6'b001111) || (cg[9:4] == 6'b110000);
    bit v4 = 1'b0;
    for (int i = 0; i < 32; i++) if (cg[9:4] == D6N[i] || cg[9:4] == D6P[i]) v6 = 1'b1;
    for (int i = 0; i < 14; i++) if (cg[3:0] == F4[i]) v4 = 1'b1;
    return v6 && v4;
  endfunction

  function automatic bit tb_is_k(input logic [9:0] cg);
    bit k = (cg[9:4] == 6'b001111) || (cg[9:4] == 6'b110000);
    for (int i = 0; i < 8; i++) if (cg == K7[i]) k = 1'b1;
    return k;
  endfunction

  function automatic bit tb_comma(input logic [9:0] cg);
    return (cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000);
  endfunction

  // Model: mode 0 lost, 1 waiting for D after comma (stage lvl),
  // 2 acquiring (stage lvl), 3 synced with error depth err (0 = clean).
  int         m_mode = 0, m_lvl = 0, m_err = 0, m_gc = 0;
  bit         m_a = 1'b0, m_even = 1'b0;
  logic [9:0] m_sudi = 10'd0;

  task automatic model_step(input logic [9:0] cg, input bit sd, input bit lb, input bit rst);
    bit vld, cm, dd, bad;
    if (rst) begin
      m_mode = 0; m_err = 0; m_gc = 0; m_a = 0; m_even = 0; m_sudi = 10'd0;
      return;
    end
    vld = tb_valid(cg);
    cm  = tb_comma(cg);
    dd  = vld && !tb_is_k(cg);
    bad = !vld || (cm && m_even);
    if (!sd && !lb) m_mode = 0;
    else case (m_mode)
      0: if (cm) begin m_mode = 1; m_lvl = 1; end
      1: begin
        if (!dd) m_mode = 0;
        else if (m_lvl == 3) begin m_mode = 3; m_err = 0; m_a = 0; end
        else m_mode = 2;
      end
      2: begin
        if (bad) m_mode = 0;
        else if (!m_even && cm) begin m_mode = 1; m_lvl++; end
      end
      default: begin
        if (m_err == 0) begin
          if (bad) begin m_err = 1; m_a = 0; m_gc = 0; end
        end else if (bad) begin
          if (m_err == 3) m_mode = 0;
          else begin m_err++; m_a = 0; m_gc = 0; end
        end else if (!m_a) begin
          m_a = 1; m_gc = 1;
        end else if (m_gc == 3) begin
          m_err--; m_a = 0;
          if (m_err > 0) m_gc = 0;
        end else m_gc++;
      end
    endcase
    m_even = (m_mode == 1) ? 1'b1 : !m_even;
    m_sudi = cg;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [9:0] cg, input bit sd, input bit lb, input bit rst);
    rx_code_group = cg;
    signal_detect = sd;
    mr_loopback   = lb;
    mr_main_reset = rst;
    @(posedge clock);
    model_step(cg, sd, lb, rst);
    #1;
    chk("status", {9'd0, code_sync_status}, {9'd0, m_mode == 3});
    chk("rx_even", {9'd0, rx_even}, {9'd0, m_even});
    chk("sudi", SUDI, m_sudi);
    $display("cg=%b sd=%0b lb=%0b rst=%0b -> status=%0b rx_even=%0b SUDI=%h",
             cg, sd, lb, rst, code_sync_status, rx_even, SUDI);
  endtask

  // Clean /K28.5/D16.2/ stream; status must rise exactly on the 6th group.
  task automatic acquire(input bit sd, input bit lb, input string tag);
    for (int i = 0; i < 6; i++) begin
      step((i % 2 == 0) ? K285 : D162, sd, lb, 1'b0);
      chk(tag, {9'd0, code_sync_status}, {9'd0, i == 5});
    end
  endtask

  initial begin
    logic [9:0] prev;
    logic [9:0] cg;
    bit sd, lb, ph;

    step(BAD, 1'b0, 1'b0, 1'b1);
    step(D162, 1'b1, 1'b0, 1'b1);
    chk("rst_status", {9'd0, code_sync_status}, 10'd0);
    chk("rst_even", {9'd0, rx_even}, 10'd0);
    chk("rst_sudi", SUDI, 10'd0);

    acquire(1'b1, 1'b0, "acq_status");
    for (int i = 0; i < 6; i++) begin
      prev = (i % 2 == 0) ? K285 : D162;
      step(prev, 1'b1, 1'b0, 1'b0);
      chk("sync_even", {9'd0, rx_even}, {9'd0, i % 2 == 0});
      chk("sync_sudi", SUDI, prev);
      chk("sync_hold", {9'd0, code_sync_status}, 10'd1);
    end

    for (int i = 0; i < 4; i++) begin
      step(BAD, 1'b1, 1'b0, 1'b0);
      chk("loss_err", {9'd0, code_sync_status}, {9'd0, i < 3});
    end

    acquire(1'b1, 1'b0, "reacq_status");
    step(BAD, 1'b1, 1'b0, 1'b0);
    chk("recov_bad", {9'd0, code_sync_status}, 10'd1);
    for (int i = 0; i < 4; i++) begin
      step(D162, 1'b1, 1'b0, 1'b0);
      chk("recov_good", {9'd0, code_sync_status}, 10'd1);
    end
    for (int i = 0; i < 4; i++) begin
      step(BAD, 1'b1, 1'b0, 1'b0);
      chk("recov_loss", {9'd0, code_sync_status}, {9'd0, i < 3});
    end

    step(BAD, 1'b1, 1'b0, 1'b0);
    step(K285, 1'b1, 1'b0, 1'b0);
    step(D162, 1'b1, 1'b0, 1'b0);
    step(D162, 1'b1, 1'b0, 1'b0);
    step(K285, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(D162, 1'b1, 1'b0, 1'b0);
      chk("misalign", {9'd0, code_sync_status}, 10'd0);
    end

    acquire(1'b1, 1'b0, "sd_acq");
    step(D162, 1'b0, 1'b0, 1'b0);
    chk("sd_drop", {9'd0, code_sync_status}, 10'd0);
    acquire(1'b0, 1'b1, "loopback_acq");

    sd = 1'b1; lb = 1'b0; ph = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 150) == 0) sd = ~sd;
      if ($urandom_range(0, 200) == 0) lb = ~lb;
      if ($urandom_range(0, 30) == 0) ph = ~ph;
      if ($urandom_range(0, 19) == 0) cg = 10'($urandom_range(0, 1023));
      else if (ph) cg = $urandom_range(0, 1) ? K285 : K285P;
      else cg = {$urandom_range(0, 1) ? D6N[$urandom_range(0, 31)] : D6P[$urandom_range(0, 31)],
                 F4[$urandom_range(0, 11)]};
      ph = ~ph;
      step(cg, sd, lb, $urandom_range(0, 499) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/synchronization.md
# synchronization

Receive-side PCS synchronization block for a 1000BASE-X style link, based on the IEEE 802.3 Clause 36 synchronization state machine. It watches the incoming 10-bit code-group stream (in the TX→SYNC loop it is driven directly by TRANSMIT's `tx_code_group`) and acquires code-group alignment from comma-bearing /K28.5/ followed by data groups. It reports `code_sync_status`, keeps the even/odd code-group parity `rx_even`, and forwards the code-groups as `SUDI` to the downstream receive logic.

## Interface
No parameters.
- `clock`  input  1  rising-edge clock, one code-group per cycle; single clock domain.
- `mr_main_reset`  input  1  reset, synchronous and active-high.
- `mr_loopback`  input  1  1 = loopback, signal_detect ignored.
- `signal_detect`  input  1  1 = OK, 0 = FAIL.
- `rx_code_group`  input  10  received code-group; bit 9 = a … bit 0 = j (abcdei fghj).
- `SUDI`  output  10  registered copy of `rx_code_group`.
- `code_sync_status`  output  1  1 = OK (sync acquired), 0 = FAIL.
- `rx_even`  output  1  1 = current code-group is even.

## Operation
- Definitions (all combinational on `rx_code_group`):
  - *comma*: bits[9:3] = 0011111 or 1100000.
  - *valid*: abcdei is in the 5b/6b table (either disparity column, including 001111/110000), and fghj is in the 3b/4b table (either column, including 0111/1000). Running disparity is not checked.
  - *K*: abcdei ∈ {001111, 110000}, or the group is one of K23.7, K27.7, K29.7, K30.7 in either disparity.
  - *D*: valid and not K.
  - *cgbad* = !valid | (comma & rx_even); *cggood* = !cgbad.
- State register: 13 states, one-hot.
- `code_sync_status` = 1 exactly in the SYNC_ACQUIRED_* states.
- Entry action on `rx_even`:
  - "toggle" means rx_even ← !rx_even.
  - "set" means rx_even ← 1.
- States and transitions. Each transition is evaluated on the current registered rx_even and the current code-group.
  - LOSS_OF_SYNC (toggle): go to COMMA_DETECT_1 when (signal_detect | mr_loopback) & comma.
  - COMMA_DETECT_1 (set): D → ACQUIRE_SYNC_1; otherwise → LOSS_OF_SYNC.
  - ACQUIRE_SYNC_1 (toggle):
    - cgbad → LOSS_OF_SYNC.
    - !rx_even & comma → COMMA_DETECT_2.
    - otherwise stay.
  - COMMA_DETECT_2 (set): D → ACQUIRE_SYNC_2; otherwise → LOSS_OF_SYNC.
  - ACQUIRE_SYNC_2 (toggle): same transitions as ACQUIRE_SYNC_1, with COMMA_DETECT_3 as the comma target.
  - COMMA_DETECT_3 (set): D → SYNC_ACQUIRED_1; otherwise → LOSS_OF_SYNC.
  - SYNC_ACQUIRED_1 (toggle): cgbad → SYNC_ACQUIRED_2; otherwise stay.
  - SYNC_ACQUIRED_n, n = 2..4 (toggle, good_cgs ← 0):
    - cggood → SYNC_ACQUIRED_nA.
    - cgbad → SYNC_ACQUIRED_(n+1); from n = 4 the cgbad target is LOSS_OF_SYNC.
  - SYNC_ACQUIRED_nA (toggle, good_cgs ← good_cgs+1):
    - cgbad → SYNC_ACQUIRED_(n+1), or LOSS_OF_SYNC for n = 4.
    - cggood with good_cgs == 3 → SYNC_ACQUIRED_(n−1); from n = 2 this is SYNC_ACQUIRED_1.
    - cggood otherwise → stay.
- `good_cgs`: 2-bit counter.
- Forced loss: signal_detect = 0 & mr_loopback = 0 forces the next state to LOSS_OF_SYNC from any state. This overrides all other transitions; reset has higher priority still.

## Timing
- Fully synchronous Moore machine. State, `rx_even`, `code_sync_status`, `SUDI` and `good_cgs` all update on the same rising edge.
- The outputs reflect the state just entered.
- `SUDI` has 1-cycle latency from `rx_code_group`.
- Reset, sampled on an edge while `mr_main_reset` = 1:
  - state = LOSS_OF_SYNC.
  - `code_sync_status` = 0, `rx_even` = 0, `SUDI` = 0, `good_cgs` = 0.
- Reset asserted mid-sync drops `code_sync_status` on that same edge.
- Acquisition latency from LOSS_OF_SYNC with a clean /K28.5/D/ stream: `code_sync_status` rises on the edge that samples the 3rd D group, i.e. the 6th code-group.
- Loss latency: from SYNC_ACQUIRED_1, 4 consecutive cgbad groups reach LOSS_OF_SYNC. Status falls on the edge sampling the 4th bad group.

## Test plan
- **Reset:** hold `mr_main_reset` = 1 for 2 cycles → status 0, `rx_even` 0, `SUDI` 0x000.
- **Acquire:** `signal_detect` = 1, drive alternating K28.5 (0011111010) and D16.2 (1001000101).
  - Status goes 1 on the 6th sampled group.
  - `rx_even` = 1 after each K28.5 thereafter.
  - `SUDI` equals the prior cycle's input.
- **Loss by errors:** after sync, drive 4 × 0000000000 → status stays 1 for 3 edges, then 0 on the 4th.
- **Error recovery:** after sync, drive 1 invalid group then 4 valid D groups → status stays 1 throughout. A second invalid group then only reaches SYNC_ACQUIRED_2, not 3.
- **Misaligned comma:** once in ACQUIRE_SYNC_1, a K28.5 sampled while `rx_even` = 1 → LOSS_OF_SYNC, and status never rises.
- **Signal detect and loopback:**
  - Deassert `signal_detect` while synced → status 0 on the next edge.
  - With `mr_loopback` = 1 and `signal_detect` = 0, the acquire sequence still reaches status 1.
